// File: rtl/fmul_seq_pkg.sv
// Shared types and sizing for the byte-serial float-multiplier sequencer.
package fmul_seq_pkg;

    localparam int OP_BYTES = 4;
    localparam int WIDTH    = 8 * OP_BYTES;
    localparam int CNT_W    = $clog2(2 * OP_BYTES);

    typedef enum logic [2:0] {
        LOAD,
        ISSUE,
        WAIT,
        FLUSH,
        DRAIN
    } state_t;

endpackage

// File: rtl/fmul_timeout_ctr.sv
// Wait-cycle counter for the multiplier handshake; flags expiry at TIMEOUT_CYCLES-1.
module fmul_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    // Saturates at the limit so a held enable can never wrap back below it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/fmul_seq_ctrl.sv
// Byte-serial sequencer: loads two operands over an 8-bit handshake, issues one
// multiply, waits with a timeout, then streams the product back out MSB-first.
module fmul_seq_ctrl
    import fmul_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_start,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_result,
    output logic             mul_clear,
    output logic             busy,
    output logic             err_timeout
);

    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(2 * OP_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(OP_BYTES - 1);
    localparam logic [CNT_W-1:0] A_BYTES  = CNT_W'(OP_BYTES);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] byte_cnt;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             consume;
    logic             expired;

    assign in_ready  = (state == LOAD) && ena;
    assign out_valid = (state == DRAIN) && ena;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign busy      = (state != LOAD);
    assign mul_start = (state == ISSUE);
    assign mul_clear = (state == FLUSH);
    assign out_byte  = result[WIDTH-1 -: 8];

    fmul_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ISSUE),
        .enable ((state == WAIT) && ena),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // A result arriving in the expiry cycle takes priority over the abort.
    always_comb begin
        next_state = state;
        unique case (state)
            LOAD:    if (accept && (byte_cnt == LAST_IN)) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT: begin
                if (mul_done) begin
                    next_state = DRAIN;
                end else if (ena && expired) begin
                    next_state = FLUSH;
                end
            end
            FLUSH:   next_state = LOAD;
            DRAIN:   if (consume && (byte_cnt == LAST_OUT)) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // One byte counter serves both the operand load and the result drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            result      <= '0;
            err_timeout <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        if (byte_cnt == '0) err_timeout <= 1'b0;
                        if (byte_cnt < A_BYTES) begin
                            mul_a <= {mul_a[WIDTH-9:0], in_byte};
                        end else begin
                            mul_b <= {mul_b[WIDTH-9:0], in_byte};
                        end
                        byte_cnt <= (byte_cnt == LAST_IN) ? '0 : byte_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (mul_done) result <= mul_result;
                end
                FLUSH: begin
                    err_timeout <= 1'b1;
                    byte_cnt    <= '0;
                end
                DRAIN: begin
                    if (consume) begin
                        result   <= {result[WIDTH-9:0], 8'h00};
                        byte_cnt <= (byte_cnt == LAST_OUT) ? '0 : byte_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_seq_ctrl.sv
// Self-checking bench for fmul_seq_ctrl: directed scenarios plus randomized
// operations compared against a transaction-level expectation model.
module tb_fmul_seq_ctrl;

    localparam int T = 16;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        ena        = 1'b0;
    logic [7:0]  in_byte    = 8'h00;
    logic        in_valid   = 1'b0;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready  = 1'b0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_start;
    logic        mul_done   = 1'b0;
    logic [31:0] mul_result = 32'h0;
    logic        mul_clear;
    logic        busy;
    logic        err_timeout;

    int          total      = 0;
    int          bad        = 0;
    int          resp_delay = 0;
    int          cd         = 0;
    logic [31:0] resp_val   = 32'h0;
    bit          exp_err    = 1'b0;

    fmul_seq_ctrl #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .mul_clear  (mul_clear),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Multiplier stand-in: pulses mul_done resp_delay cycles after mul_start (0 = never).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mul_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mul_done   = 1'b1;
                    mul_result = resp_val;
                end
            end
            if (mul_start === 1'b1 && resp_delay > 0) cd = resp_delay;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit wait_ena(input int mode, input int k);
        if (mode == 3) return !((k == 0) || (k >= 3 && k <= 12) || (k >= 17 && k <= 20));
        return 1'b1;
    endfunction

    task automatic applyStimulus(input logic [63:0] ops, input int n, input int mode);
        int i = 0;
        int tries = 0;
        int hold = 0;
        bit checked_err = 1'b0;
        while (i < n) begin
            @(posedge clk);
            #1;
            if (i > 0 && !checked_err) begin
                checkOutput("err_clear", 32'(err_timeout), 32'd0);
                checked_err = 1'b1;
            end
            ena      = 1'b1;
            in_valid = 1'b1;
            if (mode == 1) begin
                ena      = ($urandom_range(0, 3) != 0);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            if (mode == 3 && i == 3 && hold < 4) begin
                ena = 1'b0;
                hold++;
            end
            in_byte = ops[63-8*i -: 8];
            #1;
            checkOutput("in_ready", 32'(in_ready), 32'(ena));
            checkOutput("no_start", 32'(mul_start), 32'd0);
            if (in_valid && ena) begin
                i++;
                tries = 0;
            end else begin
                tries++;
                if (tries > 40) begin
                    checkOutput("feed_stall", 32'd0, 32'd1);
                    return;
                end
            end
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                         input int delay, input int mode);
        int  m;
        int  cnt;
        int  endk;
        bit  tmo;
        int  idx;
        int  tries;
        int  hold;
        resp_val   = res;
        resp_delay = delay;
        checkOutput("err_sticky", 32'(err_timeout), 32'(exp_err));
        applyStimulus({a, b}, 8, mode);
        exp_err = 1'b0;

        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ena       = wait_ena(mode, 0);
        #1;
        checkOutput("start", 32'(mul_start), 32'd1);
        checkOutput("mul_a", mul_a, a);
        checkOutput("mul_b", mul_b, b);
        checkOutput("busy_issue", 32'(busy), 32'd1);
        checkOutput("in_ready_issue", 32'(in_ready), 32'd0);

        // The T-th enabled wait cycle is the last one in which a result is still accepted.
        cnt = 0;
        m   = 0;
        for (int k = 1; k < 1000 && m == 0; k++) begin
            if (wait_ena(mode, k)) cnt++;
            if (cnt == T) m = k;
        end
        tmo  = (delay == 0) || (delay > m);
        endk = tmo ? m + 1 : delay + 1;

        for (int k = 1; k <= endk; k++) begin
            @(posedge clk);
            #1;
            ena = (k == endk) ? 1'b1 : wait_ena(mode, k);
            #1;
            if (k == 1) checkOutput("start_pulse", 32'(mul_start), 32'd0);
            if (k == endk - 1) begin
                checkOutput("early_valid", 32'(out_valid), 32'd0);
                checkOutput("early_clear", 32'(mul_clear), 32'd0);
            end
            if (k == endk) begin
                checkOutput("clear", 32'(mul_clear), 32'(tmo));
                checkOutput("first_valid", 32'(out_valid), 32'(!tmo));
                if (!tmo) checkOutput("out_byte0", 32'(out_byte), 32'(res[31:24]));
            end
        end

        if (tmo) begin
            @(posedge clk);
            #1;
            ena = 1'b1;
            #1;
            checkOutput("clear_pulse", 32'(mul_clear), 32'd0);
            checkOutput("err_set", 32'(err_timeout), 32'd1);
            checkOutput("idle_flush", 32'(busy), 32'd0);
            checkOutput("ready_flush", 32'(in_ready), 32'd1);
            exp_err = 1'b1;
            return;
        end

        idx   = 0;
        tries = 0;
        hold  = 0;
        while (idx < 4) begin
            @(posedge clk);
            #1;
            ena       = 1'b1;
            out_ready = 1'b1;
            if (mode == 1) begin
                ena       = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end
            if (mode == 2 && idx == 1 && hold < 5) begin
                out_ready = 1'b0;
                hold++;
            end
            if (mode == 3 && idx == 2 && hold < 4) begin
                ena = 1'b0;
                hold++;
            end
            #1;
            checkOutput("out_valid", 32'(out_valid), 32'(ena));
            if (ena) checkOutput("out_byte", 32'(out_byte), 32'(res[31-8*idx -: 8]));
            if (ena && out_ready) begin
                idx++;
                tries = 0;
            end else begin
                tries++;
                if (tries > 40) begin
                    checkOutput("drain_stall", 32'd0, 32'd1);
                    return;
                end
            end
        end

        @(posedge clk);
        #1;
        ena       = 1'b1;
        out_ready = 1'b0;
        #1;
        checkOutput("ready_after_drain", 32'(in_ready), 32'd1);
        checkOutput("idle_after_drain", 32'(busy), 32'd0);
        checkOutput("valid_after_drain", 32'(out_valid), 32'd0);
    endtask

    initial begin
        $display("[TB] start");
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_start", 32'(mul_start), 32'd0);
        checkOutput("rst_clear", 32'(mul_clear), 32'd0);
        checkOutput("rst_err", 32'(err_timeout), 32'd0);
        checkOutput("rst_mul_a", mul_a, 32'd0);
        checkOutput("rst_mul_b", mul_b, 32'd0);
        checkOutput("rst_out_byte", 32'(out_byte), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'h40000000, 32'h40000000, 32'h40800000, 3, 0);
        do_op(32'h40000000, 32'h40000000, 32'h40800000, 3, 2);
        do_op(32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0, 0);
        do_op(32'h3F800000, 32'h3F800000, 32'h3F800000, T, 0);

        applyStimulus(64'h40000000_40000000, 5, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_mul_a", mul_a, 32'd0);
        checkOutput("midrst_mul_b", mul_b, 32'd0);
        checkOutput("midrst_clear", 32'(mul_clear), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_err = 1'b0;
        do_op(32'h3F800000, 32'hC0000000, 32'hC0000000, 4, 0);

        do_op(32'h40400000, 32'h40000000, 32'h40C00000, 20, 3);

        for (int r = 0; r < 14; r++) begin
            do_op($urandom, $urandom, $urandom, int'($urandom_range(1, 22)),
                  int'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
